// File: rtl/stage_wb.sv
// rtl/stage_wb.sv - MEM/WB pipeline register with load alignment, misalign detect and retire counter
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module stage_wb #(
  parameter int REG_WIDTH     = `REG_WIDTH,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     EX_MEM_valid,
  input  logic                     EX_MEM_reg_write_en,
  input  logic [RF_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic [6:0]               EX_MEM_inst_opcode,
  input  logic [2:0]               EX_MEM_funct3,
  input  logic [REG_WIDTH-1:0]     EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]     DMEM_data_out,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     WB_valid,
  output logic                     WB_reg_write_en,
  output logic [RF_ADDR_WIDTH-1:0] WB_rd,
  output logic [REG_WIDTH-1:0]     WB_data,
  output logic                     WB_misalign,
  output logic [63:0]              instret
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [1:0]           offset;
  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;
  logic                 is_load;
  logic                 misaligned;
  logic [REG_WIDTH-1:0] next_data;
  logic                 next_we;
  // Low after reset; the first post-reset edge only arms capture.
  logic                 armed;

  // Select the load lane, extend it, and detect misaligned accesses.
  always_comb begin
    offset     = EX_MEM_alu_out[1:0];
    byte_lane  = DMEM_data_out[{offset, 3'b000} +: 8];
    half_lane  = offset[1] ? DMEM_data_out[31:16] : DMEM_data_out[15:0];
    is_load    = (EX_MEM_inst_opcode == OP_LOAD);
    misaligned = 1'b0;
    next_data  = EX_MEM_alu_out;
    if (is_load) begin
      case (EX_MEM_funct3)
        3'b000: next_data = {{(REG_WIDTH-8){byte_lane[7]}}, byte_lane};
        3'b001: begin
          misaligned = offset[0];
          next_data  = {{(REG_WIDTH-16){half_lane[15]}}, half_lane};
        end
        3'b100: next_data = {{(REG_WIDTH-8){1'b0}}, byte_lane};
        3'b101: begin
          misaligned = offset[0];
          next_data  = {{(REG_WIDTH-16){1'b0}}, half_lane};
        end
        // LW and the unused encodings all read the full word.
        default: begin
          misaligned = (offset != 2'b00);
          next_data  = DMEM_data_out;
        end
      endcase
      if (misaligned) next_data = '0;
    end else if (EX_MEM_inst_opcode == OP_JAL || EX_MEM_inst_opcode == OP_JALR) begin
      next_data = DMEM_data_out;
    end
    next_we = EX_MEM_valid & EX_MEM_reg_write_en & (EX_MEM_rd != '0) & ~misaligned;
  end

  // MEM/WB register and retired-instruction counter; flush beats stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed           <= 1'b0;
      WB_valid        <= 1'b0;
      WB_reg_write_en <= 1'b0;
      WB_rd           <= '0;
      WB_data         <= '0;
      WB_misalign     <= 1'b0;
      instret         <= 64'd0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (flush) begin
      WB_valid        <= 1'b0;
      WB_reg_write_en <= 1'b0;
      WB_rd           <= '0;
      WB_data         <= '0;
      WB_misalign     <= 1'b0;
    end else if (!stall) begin
      WB_valid        <= EX_MEM_valid;
      WB_reg_write_en <= next_we;
      WB_rd           <= EX_MEM_rd;
      WB_data         <= next_data;
      WB_misalign     <= EX_MEM_valid & misaligned;
      if (EX_MEM_valid) instret <= instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_stage_wb.sv
// tb/tb_stage_wb.sv - self-checking bench for stage_wb
module tb_stage_wb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_we = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [6:0]  ex_op = '0;
  logic [2:0]  ex_f3 = '0;
  logic [31:0] ex_alu = '0;
  logic [31:0] dmem = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_valid, wb_we, wb_mis;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;
  logic preload = 1'b0;

  stage_wb #(.REG_WIDTH(32), .RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .EX_MEM_valid(ex_valid), .EX_MEM_reg_write_en(ex_we), .EX_MEM_rd(ex_rd),
    .EX_MEM_inst_opcode(ex_op), .EX_MEM_funct3(ex_f3), .EX_MEM_alu_out(ex_alu),
    .DMEM_data_out(dmem), .stall(stall), .flush(flush),
    .WB_valid(wb_valid), .WB_reg_write_en(wb_we), .WB_rd(wb_rd),
    .WB_data(wb_data), .WB_misalign(wb_mis), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ALU  = 7'b0110011;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference result of one instruction, from the load size/sign rules.
  task automatic ref_wb(input logic v, input logic we, input logic [4:0] rd,
                        input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] dm,
                        output logic [31:0] data, output logic mis, output logic wen);
    int     off, size;
    bit     sgn;
    longint val;
    off = int'(alu % 4);
    mis = 1'b0;
    data = alu;
    if (op == LOAD) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd4: begin size = 1; sgn = 0; end
        3'd1: begin size = 2; sgn = 1; end
        3'd5: begin size = 2; sgn = 0; end
        default: begin size = 4; sgn = 0; end
      endcase
      mis = (off % size) != 0;
      if (mis) data = 0;
      else begin
        val = longint'(dm) / (longint'(1) << (8 * off));
        val = val % (longint'(1) << (8 * size));
        if (sgn && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
        data = val[31:0];
      end
    end else if (op == JAL || op == JALR) begin
      data = dm;
    end
    wen = v && we && rd != 0 && !mis;
  endtask

  logic        m_armed = 1'b0, m_valid = 1'b0, m_we = 1'b0, m_mis = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  logic [63:0] m_cnt = '0;

  // Behavioural model of the WB slot and retire count.
  always @(posedge clk or negedge reset_n) begin
    logic [31:0] d;
    logic        mi, w;
    logic [63:0] base;
    if (!reset_n) begin
      m_armed <= 0; m_valid <= 0; m_we <= 0; m_mis <= 0; m_rd <= 0; m_data <= 0; m_cnt <= 0;
    end else begin
      base = preload ? 64'hFFFF_FFFF_FFFF_FFFF : m_cnt;
      m_cnt <= base;
      if (!m_armed) m_armed <= 1;
      else if (flush) begin
        m_valid <= 0; m_we <= 0; m_mis <= 0; m_rd <= 0; m_data <= 0;
      end else if (!stall) begin
        ref_wb(ex_valid, ex_we, ex_rd, ex_op, ex_f3, ex_alu, dmem, d, mi, w);
        m_valid <= ex_valid; m_we <= w; m_rd <= ex_rd; m_data <= d;
        m_mis <= ex_valid && mi;
        m_cnt <= base + (ex_valid ? 64'd1 : 64'd0);
      end
    end
  end

  // Compare the DUT against the model one time unit after every edge.
  always @(posedge clk) begin
    #1;
    check("valid", wb_valid, m_valid);
    check("we", wb_we, m_we);
    check("rd", wb_rd, m_rd);
    check("data", wb_data, m_data);
    check("misalign", wb_mis, m_mis);
    check("instret", instret, m_cnt);
  end

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [6:0] op,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] dm);
    @(negedge clk);
    ex_valid = v; ex_we = we; ex_rd = rd; ex_op = op; ex_f3 = f3; ex_alu = alu; dmem = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_valid", wb_valid, 0);
    check("reset_instret", instret, 0);
    drive(1, 1, 5'd5, LOAD, 3'b000, 32'h1002, 32'h80FF7F01);
    reset_n = 1'b1;
    step();
    check("first_edge_hold", wb_valid, 0);
    step();
    check("lb_data", wb_data, 32'hFFFFFFFF);
    check("lb_rd", wb_rd, 5);
    check("lb_we", wb_we, 1);
    check("lb_instret", instret, 1);
    drive(1, 1, 5'd6, LOAD, 3'b101, 32'h1002, 32'h80FF7F01); step();
    check("lhu_data", wb_data, 32'h000080FF);
    drive(1, 1, 5'd6, LOAD, 3'b001, 32'h1003, 32'h80FF7F01); step();
    check("lh_mis", wb_mis, 1);
    check("lh_mis_we", wb_we, 0);
    check("lh_mis_data", wb_data, 0);
    drive(1, 1, 5'd1, JAL, 3'b000, 32'h0000_0200, 32'h00000104); step();
    check("jal_data", wb_data, 32'h104);
    check("jal_we", wb_we, 1);
    drive(1, 1, 5'd0, JAL, 3'b000, 32'h0000_0200, 32'h00000104); step();
    check("jal_x0_we", wb_we, 0);
    check("jal_x0_valid", wb_valid, 1);
    drive(1, 1, 5'd7, ALU, 3'b000, 32'h12345678, 32'hDEADBEEF); step();
    check("add_data", wb_data, 32'h12345678);
    check("add_instret", instret, 6);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(i + 10), ALU, 3'b000, 32'(i * 7 + 3), 32'h55);
      stall = 1'b1;
      step();
      check("stall_data", wb_data, 32'h12345678);
      check("stall_instret", instret, 6);
    end
    @(negedge clk); flush = 1'b1; step();
    check("flush_valid", wb_valid, 0);
    check("flush_instret", instret, 6);
    @(negedge clk); flush = 1'b0; stall = 1'b0;
    // Lane and size sweep, checked by the model.
    drive(1, 1, 5'd3, LOAD, 3'b000, 32'h2000, 32'h80FF7F01); step();
    check("lb_off0", wb_data, 32'h00000001);
    drive(1, 1, 5'd3, LOAD, 3'b000, 32'h2003, 32'h80FF7F01); step();
    check("lb_off3", wb_data, 32'hFFFFFF80);
    drive(1, 1, 5'd3, LOAD, 3'b100, 32'h2001, 32'h80FF7F01); step();
    drive(1, 1, 5'd3, LOAD, 3'b001, 32'h2000, 32'h80FF7F01); step();
    drive(1, 1, 5'd3, LOAD, 3'b010, 32'h2000, 32'hCAFEF00D); step();
    drive(1, 1, 5'd3, LOAD, 3'b010, 32'h2002, 32'hCAFEF00D); step();
    drive(1, 1, 5'd3, LOAD, 3'b110, 32'h2001, 32'hCAFEF00D); step();
    drive(1, 1, 5'd3, LOAD, 3'b011, 32'h2000, 32'hCAFEF00D); step();
    drive(1, 1, 5'd4, JALR, 3'b000, 32'h3001, 32'h00000888); step();
    drive(0, 1, 5'd4, ALU, 3'b000, 32'h99, 32'h0); step();
    drive(1, 0, 5'd4, ALU, 3'b000, 32'h77, 32'h0); step();
    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    preload = 1'b1;
    #1 release dut.instret;
    step();
    check("instret_wrap", instret, 0);
    preload = 1'b0;
    // Asynchronous reset mid-stream.
    drive(1, 1, 5'd9, ALU, 3'b000, 32'hABCD, 32'h0);
    @(posedge clk); #1;
    check("pre_reset_valid", wb_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", wb_valid, 0);
    check("async_we", wb_we, 0);
    check("async_data", wb_data, 0);
    check("async_instret", instret, 0);
    #4 reset_n = 1'b1;
    step();
    check("post_reset_hold", wb_valid, 0);
    step();
    check("post_reset_capture", wb_data, 32'hABCD);
    check("post_reset_instret", instret, 1);
    drive(0, 0, 5'd0, ALU, 3'b000, 32'h0, 32'h0); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
